// File: rtl/bsg_credit_returner_if.sv
// Credit return channel between a receiver-side credit returner and the sender's credit counter.
// The packet is offered with credit_v_o and completes on a cycle with credit_v_o & credit_ready_i.
// Once raised, credit_v_o and credit_count_o hold until that cycle. credit_ready_i is ignored while credit_v_o is low.
interface bsg_credit_returner_if #(
  parameter int max_step_p  = 2,
  parameter int batch_max_p = 8
);
  logic [$clog2(max_step_p+1)-1:0]  deq_i;
  logic                             credit_v_o;
  logic [$clog2(batch_max_p+1)-1:0] credit_count_o;
  logic                             credit_ready_i;
  logic                             overflow_o;

  modport master (
    input  deq_i,
    input  credit_ready_i,
    output credit_v_o,
    output credit_count_o,
    output overflow_o
  );

  modport slave (
    output deq_i,
    output credit_ready_i,
    input  credit_v_o,
    input  credit_count_o,
    input  overflow_o
  );
endinterface

// File: rtl/bsg_credit_returner.sv
// Counts freed receive-buffer entries and returns them to the sender as batched credit packets.
// Macro BSG_CREDIT_RETURNER_TIMEOUT_EN enables batching with an ACCUM timeout; otherwise credits return immediately.
module bsg_credit_returner #(
  parameter int max_step_p    = 2,
  parameter int pending_max_p = 16,
  parameter int batch_p       = 4,
  parameter int batch_max_p   = 8,
  parameter int timeout_p     = 8,
  localparam int pw = $clog2(pending_max_p+1),
  localparam int tw = (timeout_p > 1) ? $clog2(timeout_p) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bsg_credit_returner_if.master link,
  output logic [1:0]            dbg_state,
  output logic [pw-1:0]         dbg_pending,
  output logic [tw-1:0]         dbg_timer,
  output logic                  dbg_at_batch
);

  localparam int cw = $clog2(batch_max_p+1);
  localparam int sw = pw + 1;

  // Debug encoding is stable across builds: 0 IDLE, 1 ACCUM, 2 SEND.
`ifdef BSG_CREDIT_RETURNER_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, SEND = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd2} state_e;
`endif

  state_e          state_r, state_n, fresh;
  logic [pw-1:0]   pending_r, pending_n;
  logic [cw-1:0]   count_r, count_n;
  logic            credit_v_r;
  logic            overflow_r;
  logic            xfer;
  logic            ovf_now;
  logic            launch;
  logic [sw-1:0]   sum;

`ifdef BSG_CREDIT_RETURNER_TIMEOUT_EN
  logic [tw-1:0]   timer_r, timer_n;
`endif

  always_comb begin
    xfer    = credit_v_r & link.credit_ready_i;
    sum     = {1'b0, pending_r} + sw'(link.deq_i) - (xfer ? sw'(count_r) : sw'(0));
    ovf_now = (sum > sw'(pending_max_p));
    pending_n = ovf_now ? pw'(pending_max_p) : pw'(sum);

    // Decision taken whenever no packet is outstanding (IDLE, or SEND just accepted).
`ifdef BSG_CREDIT_RETURNER_TIMEOUT_EN
    if (sum >= sw'(batch_p))
      fresh = SEND;
    else if (sum != '0)
      fresh = ACCUM;
    else
      fresh = IDLE;
`else
    fresh = (sum != '0) ? SEND : IDLE;
`endif
  end

  always_comb begin
    state_n = state_r;
    count_n = count_r;
    launch  = 1'b0;
`ifdef BSG_CREDIT_RETURNER_TIMEOUT_EN
    timer_n = timer_r;
`endif
    unique case (state_r)
      IDLE: state_n = fresh;
`ifdef BSG_CREDIT_RETURNER_TIMEOUT_EN
      ACCUM: begin
        if ((sum >= sw'(batch_p)) || (timer_r == tw'(timeout_p-1)))
          state_n = SEND;
        else
          timer_n = timer_r + tw'(1);
      end
`endif
      SEND: if (xfer) state_n = fresh;
      default: state_n = IDLE;
    endcase

`ifdef BSG_CREDIT_RETURNER_TIMEOUT_EN
    if ((state_n == ACCUM) && (state_r != ACCUM))
      timer_n = '0;
`endif

    // A new packet is latched on every entry into SEND, including back-to-back after an accept.
    launch = (state_n == SEND) && ((state_r != SEND) || xfer);
    if (launch)
      count_n = (sum > sw'(batch_max_p)) ? cw'(batch_max_p) : cw'(sum);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r    <= IDLE;
      pending_r  <= '0;
      count_r    <= '0;
      credit_v_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      pending_r  <= pending_n;
      count_r    <= count_n;
      credit_v_r <= (state_n == SEND);
      overflow_r <= overflow_r | ovf_now;
    end
  end

`ifdef BSG_CREDIT_RETURNER_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)
      timer_r <= '0;
    else
      timer_r <= timer_n;
  end

  assign dbg_timer = timer_r;
`else
  assign dbg_timer = '0;
`endif

  assign link.credit_v_o     = credit_v_r;
  assign link.credit_count_o = count_r;
  assign link.overflow_o     = overflow_r;

  assign dbg_state    = state_r;
  assign dbg_pending  = pending_r;
  assign dbg_at_batch = ({1'b0, pending_r} >= sw'(batch_p));

endmodule
